led_scan_sequencer: RTL and testbench
=====================================

// Module: led_scan_sequencer
// PURPOSE
//   Timing master for the 8x8 LED matrix driver: steps the active column, inserts de-ghost blanking
//   between columns, PWM-gates column drive for global brightness, and owns the display-buffer swap
//   handshake so a new frame is latched into the display buffer only at a frame boundary (no tearing).
//   Sits between the serial shift-in front end (requester) and the column mux/decoder datapath.
// PARAMETERS
//   NCOLS       8  number of matrix columns; col_idx wraps NCOLS-1 -> 0
//   DWELL_LOG2  4  ON phase per column lasts 2**DWELL_LOG2 cycles
//   BLANK_CYC   2  blanking cycles before each column's ON phase (>=1)
//   BRIGHT_W    4  brightness width; must be <= DWELL_LOG2
// PORTS
//   clk          in   1         system clock; all state changes on posedge
//   reset        in   1         synchronous, active-high reset
//   enable       in   1         1 = scan; 0 = display dark, sequencer parked in IDLE
//   brightness   in   BRIGHT_W  duty level; 0 = off, max = (2**BRIGHT_W-1)/2**BRIGHT_W
//   swap_req     in   1         level request from front end: new frame ready in the shift chain
//   swap_ack     out  1         1-cycle pulse: swap performed; requester drops swap_req next cycle
//   buf_latch    out  1         1-cycle pulse: load shift chain into display buffer (same cycle as ack)
//   col_idx      out  $clog2(NCOLS)  active column to the column data mux
//   col_drive    out  NCOLS     one-hot column enable (PWM-gated); all 0 whenever blank=1
//   blank        out  1         1 = outputs dark (IDLE, BLANK, SWAP states)
//   frame_start  out  1         1-cycle pulse on entry to BLANK for column 0
// BEHAVIOUR
//   - Reset values: state IDLE, col_idx 0, col_drive 0, blank 1, swap_ack 0, buf_latch 0, frame_start 0.
//   - All outputs decoded from registered state/counters only; no input->output combinational path.
//   - States: IDLE, BLANK, ON, SWAP.
//     IDLE : enable=1 -> BLANK (col 0, frame_start). swap_req=1 (not in lockout) -> swap pulse, stay IDLE.
//     BLANK: lasts BLANK_CYC cycles -> ON. col_idx only ever changes on entry to BLANK.
//     ON   : lasts 2**DWELL_LOG2 cycles. At end: col<NCOLS-1 -> BLANK col+1;
//            col=NCOLS-1 and swap_req=1 -> SWAP; else -> BLANK col 0 (frame_start).
//     SWAP : exactly 1 cycle, swap_ack=buf_latch=1, blank=1 -> BLANK col 0 (frame_start).
//   - enable=0 in BLANK/ON: next cycle IDLE, col_idx 0, blank 1. enable=0 in SWAP: SWAP completes, then IDLE.
//   - PWM: brightness sampled on the cycle entering ON, held for that column. With on_cnt counting 0..2**DWELL_LOG2-1,
//     drive when on_cnt[DWELL_LOG2-1 -: BRIGHT_W] < bright_q; col_drive = onehot(col_idx) when driving else 0.
//   - Swap decision sampled only on the final ON cycle of column NCOLS-1; swap_req rising on that exact cycle is
//     serviced this frame. A swap_req dropped before the decision point is not serviced (no sticky capture).
//   - Lockout: swap_req ignored in the cycle immediately after swap_ack, so one request yields exactly one ack.
//   - Timing: column period = BLANK_CYC + 2**DWELL_LOG2; frame = NCOLS * period, +1 cycle if SWAP taken.
//   - Reset mid-operation (any state): next cycle reset values; a pending swap is abandoned, no ack issued.
//   - Counters use unsigned arithmetic, widths $clog2 of their max + 1; wrap explicitly, never by overflow.
// STRUCTURE
//   - led_matrix_pkg: state enum (IDLE/BLANK/ON/SWAP), NCOLS default, COL_W = $clog2(NCOLS) constant.
//   - One sub-module: led_phase_timer (loadable down-counter, done flag, exposes elapsed count for PWM);
//     the FSM, one-hot decode and handshake stay in led_scan_sequencer.
// TESTING (defaults: NCOLS 8, DWELL_LOG2 4, BLANK_CYC 2 -> period 18, frame 144)
//   1. reset, then enable=1, brightness=15 -> frame_start 1 cycle later; col_drive=8'h01 for 15 of 16 ON cycles;
//      blank=1 for 2 cycles between columns; col_idx steps 0..7 and frame_start repeats every 144 cycles.
//   2. brightness=0 -> col_drive stays 8'h00, blank/frame timing unchanged; brightness=8 -> 8 drive cycles/column;
//      brightness changed mid-ON -> takes effect next column only.
//   3. swap_req raised during column 3 -> one swap_ack+buf_latch pulse after column 7 ON, col_drive=0 then,
//      that frame measures 145 cycles; swap_req dropped next cycle -> no second ack.
//   4. swap_req raised on final ON cycle of column 7 -> serviced this frame; raised on first BLANK cycle of
//      column 0 -> serviced at end of following frame (144 cycles later).
//   5. enable=0 during ON of column 4 -> next cycle blank=1, col_drive=0, col_idx=0; swap_req held high while
//      disabled -> acks at cycles t+1 and t+3 (lockout between), never back-to-back.
//   6. reset asserted during SWAP and during ON -> next cycle all outputs at reset values, no swap_ack.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix scan datapath.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ON,
    ST_SWAP
  } scan_state_t;

  localparam int unsigned NCOLS_DEF = 8;
  localparam int unsigned COL_W     = $clog2(NCOLS_DEF);

endpackage

// File: rtl/led_phase_timer.sv
// Loadable phase down-counter; done when the loaded phase has fully elapsed.
// elapsed counts up from 0 alongside it and saturates, feeding the PWM compare.
module led_phase_timer #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned ELAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  output logic              done,
  output logic [ELAP_W-1:0] elapsed
);

  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      elapsed   <= '0;
    end else if (load) begin
      remaining <= load_val;
      elapsed   <= '0;
    end else if (remaining != '0) begin
      remaining <= remaining - 1'b1;
      if (elapsed != '1) elapsed <= elapsed + 1'b1;
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/led_scan_sequencer.sv
// Column scan timing master: blanking, PWM-gated column drive and
// frame-boundary display-buffer swap handshake.
module led_scan_sequencer
  import led_matrix_pkg::*;
#(
  parameter int unsigned NCOLS      = NCOLS_DEF,
  parameter int unsigned DWELL_LOG2 = 4,
  parameter int unsigned BLANK_CYC  = 2,
  parameter int unsigned BRIGHT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [BRIGHT_W-1:0]      brightness,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     buf_latch,
  output logic [$clog2(NCOLS)-1:0] col_idx,
  output logic [NCOLS-1:0]         col_drive,
  output logic                     blank,
  output logic                     frame_start
);

  localparam int unsigned CW      = $clog2(NCOLS);
  localparam int unsigned ON_CYC  = 1 << DWELL_LOG2;
  localparam int unsigned MAX_LEN = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int unsigned TW      = $clog2(MAX_LEN) + 1;

  localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] ON_LD    = TW'(ON_CYC - 1);

  scan_state_t          state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [BRIGHT_W-1:0]  bright_q;
  logic                 bright_ld;
  logic                 ack_q, ack_d;
  logic                 fs_q, fs_d;
  logic                 tmr_load, tmr_done;
  logic [TW-1:0]        tmr_val;
  logic [DWELL_LOG2-1:0] on_cnt;
  logic                 pwm_on;

  led_phase_timer #(
    .CNT_W  (TW),
    .ELAP_W (DWELL_LOG2)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done),
    .elapsed  (on_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      bright_q <= '0;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
      if (bright_ld) bright_q <= brightness;
    end
  end

  // ack_q doubles as the lockout: a request seen while the ack is still high is ignored.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    ack_d     = 1'b0;
    fs_d      = 1'b0;
    bright_ld = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = BLANK_LD;
    case (state_q)
      ST_IDLE: begin
        col_d = '0;
        if (swap_req && !ack_q) begin
          ack_d = 1'b1;
        end else if (enable) begin
          state_d  = ST_BLANK;
          fs_d     = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          col_d   = '0;
        end else if (tmr_done) begin
          state_d   = ST_ON;
          tmr_load  = 1'b1;
          tmr_val   = ON_LD;
          bright_ld = 1'b1;
        end
      end
      ST_ON: begin
        if (!enable) begin
          state_d = ST_IDLE;
          col_d   = '0;
        end else if (tmr_done) begin
          if (col_q != LAST_COL) begin
            state_d  = ST_BLANK;
            col_d    = col_q + 1'b1;
            tmr_load = 1'b1;
          end else if (swap_req && !ack_q) begin
            state_d = ST_SWAP;
            ack_d   = 1'b1;
          end else begin
            state_d  = ST_BLANK;
            col_d    = '0;
            fs_d     = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      ST_SWAP: begin
        col_d = '0;
        if (enable) begin
          state_d  = ST_BLANK;
          fs_d     = 1'b1;
          tmr_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pwm_on = (on_cnt[DWELL_LOG2-1 -: BRIGHT_W] < bright_q);

  always_comb begin
    col_drive = '0;
    if (state_q == ST_ON && pwm_on) col_drive[col_q] = 1'b1;
  end

  assign blank       = (state_q != ST_ON);
  assign col_idx     = col_q;
  assign swap_ack    = ack_q;
  assign buf_latch   = ack_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Scoreboard bench for led_scan_sequencer: per-cycle expected outputs are
// queued against absolute cycle numbers and compared by a negedge monitor.
module tb_led_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, swap_req;
  logic [3:0] brightness;
  logic       swap_ack, buf_latch, blank, frame_start;
  logic [2:0] col_idx;
  logic [7:0] col_drive;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_seen = 0;

  typedef struct {
    int          cyc;
    logic [14:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [14:0] obs;

  led_scan_sequencer #(
    .NCOLS      (8),
    .DWELL_LOG2 (4),
    .BLANK_CYC  (2),
    .BRIGHT_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .brightness  (brightness),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .buf_latch   (buf_latch),
    .col_idx     (col_idx),
    .col_drive   (col_drive),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb obs = {col_drive, blank, col_idx, frame_start, swap_ack, buf_latch};

  // Packed layout {drive[7:0], blank, col[2:0], frame_start, swap_ack, buf_latch}.
  always @(negedge clk) begin
    if (swap_ack) ack_seen++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc || obs !== mon_e.v) begin
        failures++;
        $display("FAIL scoreboard cyc=%0d entry_cyc=%0d observed=%h required=%h {drive,blank,col,fs,ack,latch}",
                 cyc, mon_e.cyc, obs, mon_e.v);
      end
    end
  end

  task automatic push_col(input int t0, input int col, input int br, input int n);
    for (int p = 0; p < n; p++) begin
      exp_t       e;
      logic [7:0] d;
      d = '0;
      if (p >= 2 && (p - 2) < br) d[col] = 1'b1;
      e.cyc = t0 + p;
      e.v   = {d, (p < 2), 3'(col), (col == 0 && p == 0), 1'b0, 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_frame(input int t0, input int br);
    for (int c = 0; c < 8; c++) push_col(t0 + 18 * c, c, br, 18);
  endtask

  task automatic push_idle(input int t, input logic a);
    exp_t e;
    e.cyc = t;
    e.v   = {8'h00, 1'b1, 3'd0, 1'b0, a, a};
    exp_q.push_back(e);
  endtask

  task automatic push_swap(input int t);
    exp_t e;
    e.cyc = t;
    e.v   = {8'h00, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic restart();
    enable   = 1'b0;
    swap_req = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; swap_req = 1'b0; brightness = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (col_idx !== 3'd0)     begin failures++; $display("FAIL reset_col_idx got=%h req=0", col_idx); end
    checks++; if (col_drive !== 8'h00)  begin failures++; $display("FAIL reset_col_drive got=%h req=00", col_drive); end
    checks++; if (blank !== 1'b1)       begin failures++; $display("FAIL reset_blank got=%b req=1", blank); end
    checks++; if (swap_ack !== 1'b0)    begin failures++; $display("FAIL reset_swap_ack got=%b req=0", swap_ack); end
    checks++; if (buf_latch !== 1'b0)   begin failures++; $display("FAIL reset_buf_latch got=%b req=0", buf_latch); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b req=0", frame_start); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (blank !== 1'b1 || col_drive !== 8'h00 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL idle_disabled got blank=%b drive=%h fs=%b req blank=1 drive=00 fs=0",
               blank, col_drive, frame_start);
    end
  endtask

  task automatic test_scan();
    int base;
    restart();
    brightness = 4'd15;
    enable     = 1'b1;
    base       = cyc + 1;
    push_frame(base, 15);
    push_col(base + 144, 0, 15, 18);
    drain("scan");
  endtask

  task automatic test_pwm();
    int base;
    restart();
    brightness = 4'd0;
    enable     = 1'b1;
    base       = cyc + 1;
    push_col(base,      0, 0, 18);
    push_col(base + 18, 1, 0, 18);
    push_col(base + 36, 2, 8, 18);
    push_col(base + 54, 3, 2, 18);
    wait_cyc(base + 36);
    brightness = 4'd8;
    wait_cyc(base + 41);
    brightness = 4'd2;
    drain("pwm");
  endtask

  task automatic test_swap();
    int base, a0;
    restart();
    brightness = 4'd15;
    enable     = 1'b1;
    base       = cyc + 1;
    a0         = ack_seen;
    push_frame(base, 15);
    push_swap(base + 144);
    push_frame(base + 145, 15);
    push_col(base + 289, 0, 15, 18);
    wait_cyc(base + 58);
    swap_req = 1'b1;
    wait_cyc(base + 145);
    swap_req = 1'b0;
    drain("swap");
    checks++;
    if (ack_seen - a0 != 1) begin
      failures++;
      $display("FAIL swap_ack_count got=%0d req=1", ack_seen - a0);
    end
  endtask

  task automatic test_swap_edge();
    int base;
    restart();
    brightness = 4'd15;
    enable     = 1'b1;
    base       = cyc + 1;
    push_frame(base, 15);
    push_swap(base + 144);
    push_frame(base + 145, 15);
    push_swap(base + 289);
    push_col(base + 290, 0, 15, 18);
    wait_cyc(base + 143);
    swap_req = 1'b1;
    wait_cyc(base + 144);
    swap_req = 1'b0;
    wait_cyc(base + 145);
    swap_req = 1'b1;
    wait_cyc(base + 289);
    swap_req = 1'b0;
    drain("swap_edge");
  endtask

  task automatic test_disable();
    int base;
    restart();
    brightness = 4'd15;
    enable     = 1'b1;
    base       = cyc + 1;
    for (int c = 0; c < 4; c++) push_col(base + 18 * c, c, 15, 18);
    push_col(base + 72, 4, 15, 7);
    for (int k = 0; k < 8; k++) push_idle(base + 79 + k, (k == 1 || k == 3 || k == 5));
    wait_cyc(base + 78);
    enable   = 1'b0;
    swap_req = 1'b1;
    wait_cyc(base + 84);
    swap_req = 1'b0;
    drain("disable");
  endtask

  task automatic test_reset_mid();
    int base, base2;
    restart();
    brightness = 4'd15;
    enable     = 1'b1;
    base       = cyc + 1;
    push_frame(base, 15);
    push_swap(base + 144);
    push_idle(base + 145, 1'b0);
    wait_cyc(base + 60);
    swap_req = 1'b1;
    wait_cyc(base + 144);
    reset = 1'b1;
    wait_cyc(base + 145);
    reset    = 1'b0;
    swap_req = 1'b0;
    base2    = base + 146;
    push_frame(base2, 15);
    push_idle(base2 + 144, 1'b0);
    push_idle(base2 + 145, 1'b0);
    wait_cyc(base2 + 40);
    swap_req = 1'b1;
    wait_cyc(base2 + 143);
    reset = 1'b1;
    wait_cyc(base2 + 144);
    reset    = 1'b0;
    enable   = 1'b0;
    swap_req = 1'b0;
    drain("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_swap();
    test_swap_edge();
    test_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
